// File: rtl/lcd_pkg.sv
// Shared LCD definitions: FSM encodings, panel commands and RGB565 colours.
// Imported by the SPI writer and by the char/clear/init generators.
package lcd_pkg;

  localparam int ST_W = 6;

  localparam int S_IDLE  = 0;
  localparam int S_SETUP = 1;
  localparam int S_SHIFT = 2;
  localparam int S_HOLD  = 3;
  localparam int S_DONE  = 4;
  localparam int S_GAP   = 5;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_SETUP = 6'b000010;
  localparam logic [5:0] ST_SHIFT = 6'b000100;
  localparam logic [5:0] ST_HOLD  = 6'b001000;
  localparam logic [5:0] ST_DONE  = 6'b010000;
  localparam logic [5:0] ST_GAP   = 6'b100000;

  localparam logic [8:0] CMD_CASET = 9'h02A;
  localparam logic [8:0] CMD_RASET = 9'h02B;
  localparam logic [8:0] CMD_RAMWR = 9'h02C;

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  function automatic logic [8:0] lcd_word(
    input logic       dc,
    input logic [7:0] b
  );
    return {dc, b};
  endfunction

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period divider: o_tick high one cycle in every CLK_DIV.
// Ports: sys_clk, sys_rst_n, i_clr (sync restart), o_tick.
module lcd_spi_tick
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/lcd_spi_writer.sv
// 9-bit {dc,byte} to 4-wire SPI (mode 0, MSB first) with wr_done pulse.
// Ports: en_write/data in; wr_done, lcd_cs/dc/scl/sda, busy out.
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_scl,
  output logic       lcd_sda,
  output logic       busy
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_nxt;
  logic            w_tick;
  logic            w_clr;
  logic            w_last;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit;
  logic [GW-1:0]   r_gap;
  logic            r_done;
  logic            r_cs;
  logic            r_dc;
  logic            r_scl;
  logic            r_sda;
  logic            r_busy;

  // Divider restarts on every state change so each state
  // gets whole half-periods.
  assign w_clr = (w_nxt != r_state);

  lcd_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_clr    (w_clr),
    .o_tick   (w_tick)
  );

  // Falling SCL of the eighth bit ends the shift phase.
  assign w_last = w_tick & r_scl & (r_bit == 3'd7);

  always_comb begin
    w_nxt = r_state;
    unique case (1'b1)
      r_state[S_IDLE]:
        if (en_write) w_nxt = ST_SETUP;
      r_state[S_SETUP]:
        if (w_tick) w_nxt = ST_SHIFT;
      r_state[S_SHIFT]:
        if (w_last) w_nxt = ST_HOLD;
      r_state[S_HOLD]:
        if (w_tick) w_nxt = ST_DONE;
      r_state[S_DONE]:
        w_nxt = ST_GAP;
      r_state[S_GAP]:
        if (r_gap == GAP_LAST) w_nxt = ST_IDLE;
      default:
        w_nxt = ST_IDLE;
    endcase
  end

  // Outputs are updated on the same edge as the state they
  // belong to, so pins and state stay cycle-aligned.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
      r_dc    <= 1'b0;
      r_scl   <= 1'b0;
      r_sda   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= 1'b0;
      unique case (1'b1)
        r_state[S_IDLE]: begin
          if (en_write) begin
            r_shift <= data[7:0];
            r_dc    <= data[8];
            r_sda   <= data[7];
            r_cs    <= 1'b0;
            r_scl   <= 1'b0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
          end
        end
        r_state[S_SETUP]: begin
        end
        r_state[S_SHIFT]: begin
          if (w_tick) begin
            if (!r_scl) begin
              r_scl <= 1'b1;
            end else begin
              r_scl <= 1'b0;
              r_bit <= r_bit + 3'd1;
              if (r_bit != 3'd7) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_sda   <= r_shift[6];
              end
            end
          end
        end
        r_state[S_HOLD]: begin
          if (w_tick) begin
            r_done <= 1'b1;
            r_cs   <= 1'b1;
          end
        end
        r_state[S_DONE]: begin
          r_gap <= '0;
        end
        r_state[S_GAP]: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GAP_LAST) r_busy <= 1'b0;
        end
        default: begin
          r_cs   <= 1'b1;
          r_scl  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign wr_done = r_done;
  assign lcd_cs  = r_cs;
  assign lcd_dc  = r_dc;
  assign lcd_scl = r_scl;
  assign lcd_sda = r_sda;
  assign busy    = r_busy;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer: defaults (dut0)
// and CLK_DIV=1/GAP_CYCLES=2 (dut1).
module tb_lcd_spi_writer;
  import lcd_pkg::*;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       en   [2];
  logic [8:0] dat  [2];
  logic       done [2];
  logic       cs   [2];
  logic       dc   [2];
  logic       scl  [2];
  logic       sda  [2];
  logic       busy [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic       scl_p  [2];
  logic       busy_p [2];
  logic       dc_p   [2];
  logic [7:0] rx     [2];
  int         nb     [2];
  int         per    [2];
  int         lr     [2];
  int         dc_bad [2];
  int         q_lat  [2][$];
  int         q_dn   [2][$];
  int         q_nb   [2][$];
  logic [8:0] q_w    [2][$];

  logic [8:0] seq [16];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  lcd_spi_writer u_dut0 (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst_n),
    .en_write (en[0]),
    .data     (dat[0]),
    .wr_done  (done[0]),
    .lcd_cs   (cs[0]),
    .lcd_dc   (dc[0]),
    .lcd_scl  (scl[0]),
    .lcd_sda  (sda[0]),
    .busy     (busy[0])
  );

  lcd_spi_writer #(
    .CLK_DIV   (1),
    .GAP_CYCLES(2)
  ) u_dut1 (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst_n),
    .en_write (en[1]),
    .data     (dat[1]),
    .wr_done  (done[1]),
    .lcd_cs   (cs[1]),
    .lcd_dc   (dc[1]),
    .lcd_scl  (scl[1]),
    .lcd_sda  (sda[1]),
    .busy     (busy[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int lim);
    int c = 0;
    while (!done[d] && c < lim) begin
      step;
      c++;
    end
    chk("wr_done_seen", {31'd0, done[d]}, 1);
  endtask

  task automatic stream(input int d, input int n);
    dat[d] = seq[0];
    en[d]  = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_done(d, 200);
      if (i + 1 < n) begin
        step;
        step;
        dat[d] = seq[i+1];
      end else begin
        en[d] = 1'b0;
      end
    end
  endtask

  // Line monitor: SDA captured on SCL rise, one word per wr_done.
  initial begin
    for (int d = 0; d < 2; d++) begin
      scl_p[d] = 0; busy_p[d] = 0; dc_p[d] = 0;
      rx[d] = 0; nb[d] = 0; per[d] = 0;
      lr[d] = 0; dc_bad[d] = 0;
    end
    forever begin
      @(negedge sys_clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          nb[d] = 0;
        end else begin
          if (scl[d] && !scl_p[d]) begin
            rx[d] = {rx[d][6:0], sda[d]};
            nb[d]++;
            if (nb[d] > 1) per[d] = cyc - lr[d];
            lr[d] = cyc;
          end
          if (busy[d] && !busy_p[d]) q_lat[d].push_back(cyc);
          if (dc[d] !== dc_p[d] && !(busy[d] && !busy_p[d]))
            dc_bad[d]++;
          if (done[d]) begin
            q_w[d].push_back({dc[d], rx[d]});
            q_nb[d].push_back(nb[d]);
            q_dn[d].push_back(cyc);
            nb[d] = 0;
          end
        end
        scl_p[d]  = scl[d];
        busy_p[d] = busy[d];
        dc_p[d]   = dc[d];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lb, b, csbad, ndone, bad;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0;
      dat[d] = '0;
    end
    repeat (3) step;
    chk("rst_done", {31'd0, done[0]}, 0);
    chk("rst_cs",   {31'd0, cs[0]},   1);
    chk("rst_dc",   {31'd0, dc[0]},   0);
    chk("rst_scl",  {31'd0, scl[0]},  0);
    chk("rst_sda",  {31'd0, sda[0]},  0);
    chk("rst_busy", {31'd0, busy[0]}, 0);
    chk("rst_cs1",  {31'd0, cs[1]},   1);
    rst_n = 1'b1;
    repeat (2) step;

    // 1: single CASET pulse
    base = q_w[0].size();
    dat[0] = CMD_CASET;
    en[0] = 1'b1;
    step;
    en[0] = 1'b0;
    csbad = 0;
    ndone = 0;
    for (int j = 1; j < 60; j++) begin
      step;
      if (j <= 35 && cs[0] !== 1'b0) csbad++;
      if (done[0]) ndone++;
      if (j == 36) begin
        chk("t1_done_k36", {31'd0, done[0]}, 1);
        chk("t1_cs_done", {31'd0, cs[0]}, 1);
      end
    end
    chk("t1_cs_low", csbad, 0);
    chk("t1_ndone", ndone, 1);
    chk("t1_nbytes", q_w[0].size() - base, 1);
    b = q_w[0].size() - 1;
    chk("t1_word", q_w[0][b], 9'h02A);
    chk("t1_bits", q_nb[0][b], 8);
    chk("t1_lat", q_dn[0][b] - q_lat[0][q_lat[0].size()-1], 36);
    chk("t1_idle", {31'd0, busy[0]}, 0);

    // 2: held en_write, fresh data per byte
    base = q_w[0].size();
    lb = q_lat[0].size();
    seq[0] = 9'h1F8;
    seq[1] = 9'h107;
    stream(0, 2);
    repeat (10) step;
    chk("t2_nbytes", q_w[0].size() - base, 2);
    chk("t2_w0", q_w[0][base], 9'h1F8);
    chk("t2_w1", q_w[0][base+1], 9'h107);
    chk("t2_period", q_lat[0][lb+1] - q_lat[0][lb], 41);

    // 3: en_write dropped mid-shift, data scrambled
    base = q_w[0].size();
    dat[0] = 9'h155;
    en[0] = 1'b1;
    step;
    repeat (12) step;
    en[0] = 1'b0;
    dat[0] = 9'h0AA;
    wait_done(0, 100);
    repeat (60) step;
    chk("t3_nbytes", q_w[0].size() - base, 1);
    chk("t3_word", q_w[0][base], 9'h155);
    chk("t3_bits", q_nb[0][base], 8);
    chk("t3_cs", {31'd0, cs[0]}, 1);
    chk("t3_busy", {31'd0, busy[0]}, 0);

    // 4: reset in the middle of bit 4
    base = q_w[0].size();
    dat[0] = 9'h0C3;
    en[0] = 1'b1;
    step;
    en[0] = 1'b0;
    repeat (15) step;
    chk("t4_bits_pre", nb[0], 3);
    rst_n = 1'b0;
    #1;
    chk("t4_cs", {31'd0, cs[0]}, 1);
    chk("t4_scl", {31'd0, scl[0]}, 0);
    chk("t4_busy", {31'd0, busy[0]}, 0);
    repeat (3) step;
    rst_n = 1'b1;
    repeat (40) step;
    chk("t4_no_done", q_w[0].size() - base, 0);
    seq[0] = 9'h0C3;
    stream(0, 1);
    repeat (10) step;
    chk("t4_word", q_w[0][base], 9'h0C3);
    chk("t4_bits", q_nb[0][base], 8);

    // 5: fast instance, window sequence
    base = q_w[1].size();
    lb = q_lat[1].size();
    seq[0]  = 9'h02A; seq[1]  = 9'h100;
    seq[2]  = 9'h100; seq[3]  = 9'h100;
    seq[4]  = 9'h1EF; seq[5]  = 9'h02B;
    seq[6]  = 9'h100; seq[7]  = 9'h100;
    seq[8]  = 9'h100; seq[9]  = 9'h19F;
    seq[10] = 9'h02C;
    stream(1, 11);
    repeat (10) step;
    chk("t5_nbytes", q_w[1].size() - base, 11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("t5_w%0d", i), q_w[1][base+i], seq[i]);
    bad = 0;
    for (int i = 1; i < 11; i++)
      if (q_lat[1][lb+i] - q_lat[1][lb+i-1] != 22) bad++;
    chk("t5_period", bad, 0);
    chk("t5_scl_per", per[1], 2);
    chk("t1_scl_per", per[0], 4);

    // 6: alternating D/C
    base = q_w[0].size();
    seq[0] = 9'h0A5;
    seq[1] = 9'h15A;
    seq[2] = 9'h03C;
    stream(0, 3);
    repeat (10) step;
    chk("t6_w0", q_w[0][base], 9'h0A5);
    chk("t6_w1", q_w[0][base+1], 9'h15A);
    chk("t6_w2", q_w[0][base+2], 9'h03C);
    chk("dc_stable0", dc_bad[0], 0);
    chk("dc_stable1", dc_bad[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
